// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-style front end: word width, the opcodes
// the fetch stage decodes, and the fetch-stage state encoding.
package mips_pkg;

   localparam int XLEN = 32;

   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;

   typedef enum logic [1:0] {
      LOAD,
      RUN,
      HALT
   } fetch_state_e;

endpackage

// File: rtl/instr_mem.sv
// Single-port instruction RAM with synchronous read; one address serves both
// the load writes and the run-time fetch reads.
module instr_mem
   import mips_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   rdata
);

   logic [XLEN-1:0] mem_q [MEM_DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
      rdata <= mem_q[addr];
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: loads the program into instr_mem, fetches the word
// at the incoming PC each cycle and halts once the PC runs past the program.
module instr_fetch
   import mips_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load_valid,
   input  logic [XLEN-1:0] load_data,
   input  logic            load_done,
   output logic            load_ready,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] instr,
   output logic            instr_valid,
   output logic            jmp_signal,
   output logic [25:0]     jmp_adr,
   output logic            is_beq,
   output logic [XLEN-1:0] beq_off,
   output logic            halted
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   prog_len_q, prog_len_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;

   logic              full;
   logic              accept;
   logic [ADDR_W:0]   len_next;
   logic              in_range;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_rdata;
   logic [5:0]        opcode;

   assign full     = (wr_ptr_q == (ADDR_W+1)'(MEM_DEPTH));
   assign accept   = (state_q == LOAD) && load_valid && !full;
   assign len_next = wr_ptr_q + {{ADDR_W{1'b0}}, accept};
   // Full-width compare so a PC at or beyond MEM_DEPTH never aliases.
   assign in_range = (pc < {{(XLEN-ADDR_W-1){1'b0}}, prog_len_q});

   assign mem_we   = accept && !rst;
   assign mem_addr = (state_q == LOAD) ? wr_ptr_q[ADDR_W-1:0] : pc[ADDR_W-1:0];

   instr_mem #(
      .MEM_DEPTH(MEM_DEPTH),
      .ADDR_W   (ADDR_W)
   ) u_mem (
      .clk  (clk),
      .we   (mem_we),
      .addr (mem_addr),
      .wdata(load_data),
      .rdata(mem_rdata)
   );

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      prog_len_d = prog_len_q;
      valid_d    = 1'b0;
      halted_d   = halted_q;
      unique case (state_q)
         LOAD: begin
            wr_ptr_d = len_next;
            if (load_done) begin
               prog_len_d = len_next;
               if (len_next == '0) begin
                  state_d  = HALT;
                  halted_d = 1'b1;
               end else begin
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            if (in_range) begin
               valid_d = 1'b1;
            end else begin
               halted_d = 1'b1;
               state_d  = HALT;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= LOAD;
         wr_ptr_q   <= '0;
         prog_len_q <= '0;
         valid_q    <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         prog_len_q <= prog_len_d;
         valid_q    <= valid_d;
         halted_q   <= halted_d;
      end
   end

   // The RAM read register holds the fetched word; it is masked to zero
   // whenever no valid fetch happened on the last edge.
   assign instr       = valid_q ? mem_rdata : '0;
   assign instr_valid = valid_q;
   assign halted      = halted_q;
   assign load_ready  = (state_q == LOAD) && !full;

   assign opcode     = instr[31:26];
   assign jmp_signal = valid_q && (opcode == OP_J);
   assign is_beq     = valid_q && (opcode == OP_BEQ);
   assign jmp_adr    = instr[25:0];
   assign beq_off    = {{(XLEN-16){instr[15]}}, instr[15:0]};

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage directly downstream of the PC generator: it holds the program in a word-addressed instruction memory, reads the word at the incoming PC each cycle, and presents the registered instruction to decode. It also extracts the jump/branch fields that the PC generator consumes (`jmp_adr`, `jmp_signal`, sign-extended branch offset). It replaces simulation-only end-of-program handling with a real halt state, entered when the PC runs past the loaded program length.

## Interface
- `MEM_DEPTH`, 256: instruction memory depth in 32-bit words.
- `ADDR_W`, 8: memory index width; must satisfy 2^ADDR_W == MEM_DEPTH.
- `clk`  in  1: single clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset; has priority over all other inputs.
- `load_valid`  in  1: the program word on `load_data` is valid.
- `load_data`  in  32: program word to write at the next load address.
- `load_done`  in  1: end of program load; may coincide with a final `load_valid`.
- `load_ready`  out  1: the block accepts load words; equals (state==LOAD && !full).
- `pc`  in  32: word address from the PC generator.
- `instr`  out  32: registered instruction word.
- `instr_valid`  out  1: `instr` holds a fetched program word.
- `jmp_signal`  out  1: `instr_valid` && opcode==J.
- `jmp_adr`  out  26: `instr[25:0]`.
- `is_beq`  out  1: `instr_valid` && opcode==BEQ. Branch-taken is decided downstream.
- `beq_off`  out  32: `instr[15:0]`, sign-extended.
- `halted`  out  1: sticky; the program has ended.

## Operation
- States: LOAD, RUN, HALT. Reset state is LOAD.
- Internal registers:
  - `wr_ptr`: ADDR_W+1 bits.
  - `prog_len`: ADDR_W+1 bits, the number of valid words.
- LOAD:
  - Write on each cycle with `load_valid && load_ready`: mem[wr_ptr] <= `load_data`, then `wr_ptr` increments.
  - full = (wr_ptr == MEM_DEPTH). When full, `load_ready` is 0 and `load_valid` is ignored.
  - On `load_done`: `prog_len` <= `wr_ptr`, plus 1 if a word is written in the same cycle. The next state is RUN, or HALT if the resulting length is 0.
  - If full and `load_done` has not arrived: remain in LOAD until `load_done`. Words offered while full are dropped and are not counted.
- RUN, evaluated each cycle:
  - If pc < prog_len (unsigned, full 32-bit compare): `instr` <= mem[pc[ADDR_W-1:0]] and `instr_valid` <= 1.
  - Otherwise: `instr` <= 0, `instr_valid` <= 0, `halted` <= 1, and the next state is HALT.
  - A PC of MEM_DEPTH or more is always past the end. No aliasing occurs.
- HALT:
  - `instr` = 0 and `instr_valid` = 0.
  - `pc`, `load_valid` and `load_done` are ignored.
  - Only `rst` leaves this state.
- Decode outputs are combinational from the registered `instr`. Opcode = `instr[31:26]`.
- Reset values:
  - `instr` = 0, `instr_valid` = 0, `halted` = 0.
  - `wr_ptr` = 0, `prog_len` = 0, state = LOAD.
  - `load_ready` therefore reads 1 in the first cycle after `rst` deasserts.
  - Writes are suppressed while `rst` is high.
  - Memory contents are not cleared.
- Reset mid-load or mid-run: all of the above are reinitialised, and the previous program length is discarded.

## Timing
- Fetch latency is 1 cycle. The `pc` sampled at posedge N appears on `instr`, and on the decode outputs, after posedge N.
- The PC generator drives `pc` from a register updated on the same edge. The block therefore sees the previous edge's PC, which gives a fixed 1-cycle fetch pipeline. Decode accounts for this.
- Load accepts 1 word per cycle with no stall except full.
- The transition LOAD→RUN takes effect on the edge after `load_done` is sampled. The first fetch happens on the following edge.
- `halted` rises on the same edge on which the out-of-range PC is sampled.

## Structure
- Shared package `mips_pkg`:
  - `XLEN` = 32.
  - Opcode constants `OP_J` = 6'b000010 and `OP_BEQ` = 6'b000100.
  - Fetch state enum {LOAD, RUN, HALT}.
- Sub-module `instr_mem`: single-port, synchronous-read RAM.
  - Parameters: `MEM_DEPTH`, `ADDR_W`.
  - Ports: `clk`, `we`, `addr`, `wdata`, `rdata`.
  - The parent muxes the address between `wr_ptr` in LOAD and `pc` in RUN.
- The FSM, counters, range check and decode stay in `instr_fetch`.

## Test plan
- **Load and run.** Load 3 words, 0x20080005, 0x08000002, 0x10000003, with `load_done` on the 3rd word. Then drive pc=0,1,2 → `prog_len` is 3. `instr` follows 1 cycle later. The word at pc=1 gives `jmp_signal`=1 and `jmp_adr`=0x0000002. The word at pc=2 gives `is_beq`=1 and `beq_off`=0x00000003.
- **Negative offset.** Load the BEQ word 0x1000FFFE and fetch it → `beq_off`=0xFFFFFFFE and `is_beq`=1.
- **End of program.** With `prog_len`=3, drive pc=3 → `instr_valid`=0 and `instr`=0 after the edge, `halted`=1, and the block stays halted for any later pc.
- **Full memory.** Offer 260 words, then `load_done` → `load_ready` drops after the 256th word and `prog_len`=256. A fetch at pc=255 returns word 255. A fetch at pc=256 halts.
- **Empty program.** Assert `load_done` with no words → the block goes directly to HALT and `halted`=1.
- **Mid-run reset.** Assert `rst` for 1 cycle during RUN → the next cycle shows `instr_valid`=0, `halted`=0, `load_ready`=1 and `prog_len`=0. A reload of 1 word works and the old contents are overwritten.
